display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller_if.sv | 20 ++
 rtl/display_scan_controller.sv | 114 +++++++++++
 tb/tb_display_scan_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - update handshake bundle for the display scan controller
interface display_scan_controller_if;
  logic        upd_valid;
  logic [15:0] upd_digits;
  logic        upd_ready;

  // Producer side offers a 4-digit value and watches for the buffer to free up
  modport master (
    output upd_valid,
    output upd_digits,
    input  upd_ready
  );

  // Controller side accepts a value whenever its one-entry buffer is empty
  modport slave (
    input  upd_valid,
    input  upd_digits,
    output upd_ready
  );
endinterface

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit multiplexed seven-segment scan with blanking and double buffering
module display_scan_controller #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  display_scan_controller_if.slave   upd,
  input  logic                       lzb,
  output logic [3:0]                 number,
  output logic [3:0]                 anodes,
  output logic                       frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pending_q, pending_d;
  logic             ready_q, ready_d;
  logic [3:0]       number_q, number_d;
  logic [3:0]       anodes_q, anodes_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end;
  logic             frame_end;
  logic [15:0]      upper_digits;
  logic [3:0]       code_d;
  logic             suppress;

  // State register; reset parks the scan at the start of the digit-0 blanking phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      active_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      ready_q      <= 1'b1;
      number_q     <= 4'h0;
      anodes_q     <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      number_q     <= number_d;
      anodes_q     <= anodes_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Blank/show phase: anodes stay off for the first BLANK_CYCLES of every slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (cnt_q == CNT_LAST)   state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Slot/digit counters and the pending-to-active hand-off at the frame boundary
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (digit_q == 2'd3);
    cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
    digit_d   = slot_end ? digit_q + 2'd1 : digit_q;
    active_d  = active_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    if (frame_end && !ready_q) begin
      // Buffered value takes over for the whole next frame
      active_d = pending_q;
      ready_d  = 1'b1;
    end else if (upd.upd_valid && ready_q) begin
      // An offer on a boundary with an empty buffer waits one more frame
      pending_d = upd.upd_digits;
      ready_d   = 1'b0;
    end
  end

  // Registered outputs computed from next-cycle state so they line up with the counters
  always_comb begin
    upper_digits = active_d >> {digit_d, 2'b00};
    code_d       = upper_digits[3:0];
    suppress     = (code_d > 4'd9) ||
                   (lzb && (digit_d != 2'd0) && (upper_digits == 16'h0000));
    number_d     = code_d;
    anodes_d     = 4'b1111;
    if ((state_d == ST_SHOW) && !suppress) begin
      anodes_d = ~(4'b0001 << digit_d);
    end
    frame_done_d = (digit_d == 2'd3) && (cnt_d == CNT_LAST);
  end

  assign upd.upd_ready = ready_q;
  assign number        = number_q;
  assign anodes        = anodes_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lzb = 1'b0;
  logic [3:0] number;
  logic [3:0] anodes;
  logic       frame_done;

  display_scan_controller_if upd_if ();

  display_scan_controller #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .upd        (upd_if),
    .lzb        (lzb),
    .number     (number),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          t = 0;
  logic [15:0] m_active = 16'h0000;
  logic [15:0] m_pending = 16'h0000;
  bit          m_pend = 1'b0;

  // One comparison point
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs follow from the time since reset and the displayed value
  task automatic check_outputs();
    int          cnt;
    int          d;
    logic [15:0] upper;
    logic [3:0]  code;
    logic [3:0]  exp_an;
    cnt    = t % CLK_DIV;
    d      = (t / CLK_DIV) % 4;
    upper  = m_active >> (4 * d);
    code   = upper[3:0];
    exp_an = 4'b1111;
    if (cnt >= BLANK && code <= 4'd9 && !(lzb && d > 0 && upper == 16'h0000))
      exp_an = ~(4'b0001 << d);
    chk("anodes", {12'h0, anodes}, {12'h0, exp_an});
    chk("number", {12'h0, number}, {12'h0, code});
    chk("frame_done", {15'h0, frame_done}, {15'h0, ((t % FRAME) == FRAME - 1)});
    chk("upd_ready", {15'h0, upd_if.upd_ready}, {15'h0, !m_pend});
  endtask

  // Advance one clock, update the reference model, then check all outputs
  task automatic step();
    bit bnd;
    @(posedge clk);
    if (reset) begin
      t        = 0;
      m_active = 16'h0000;
      m_pend   = 1'b0;
    end else begin
      bnd = ((t % FRAME) == FRAME - 1);
      if (bnd && m_pend) begin
        m_active = m_pending;
        m_pend   = 1'b0;
      end else if (upd_if.upd_valid && !m_pend) begin
        m_pending = upd_if.upd_digits;
        m_pend    = 1'b1;
      end
      t++;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the current cycle sits at the given frame position (bounded by one frame)
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step();
    chk("run_to_pos", 16'((t % FRAME)), 16'(pos));
  endtask

  task automatic offer(input logic [15:0] v);
    upd_if.upd_valid  = 1'b1;
    upd_if.upd_digits = v;
    step();
    upd_if.upd_valid  = 1'b0;
  endtask

  initial begin
    upd_if.upd_valid  = 1'b0;
    upd_if.upd_digits = 16'h0000;

    // Reset state
    run(2);
    reset = 1'b0;

    // Idle scan of zeros over more than one frame
    run(40);

    // Mid-frame update of 1234; ready drops, applied at next boundary
    run_to(10);
    offer(16'h1234);
    chk("ready_after_offer", {15'h0, upd_if.upd_ready}, 16'h0000);
    run(2 * FRAME);

    // Leading-zero blanking on 0050, then with blanking disabled
    lzb = 1'b1;
    offer(16'h0050);
    run(2 * FRAME);
    lzb = 1'b0;
    run(FRAME);

    // Non-decimal code in digit 1 is suppressed
    offer(16'h00A7);
    run(2 * FRAME);

    // Offer on the boundary with empty buffer, then a second offer that must be ignored
    run_to(FRAME - 1);
    offer(16'h5678);
    chk("ready_low_boundary_offer", {15'h0, upd_if.upd_ready}, 16'h0000);
    offer(16'h9999);
    run(2 * FRAME);

    // Reset mid-show of digit 2 with an update pending
    run_to(2);
    offer(16'h4321);
    run_to(2 * CLK_DIV + 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_anodes", {12'h0, anodes}, 16'h000F);
    chk("rst_number", {12'h0, number}, 16'h0000);
    chk("rst_ready", {15'h0, upd_if.upd_ready}, 16'h0001);
    run(2 * FRAME);

    // Randomized traffic with occasional resets and lzb changes
    for (int i = 0; i < 2000; i++) begin
      upd_if.upd_valid = ($urandom_range(0, 3) == 0);
      for (int n = 0; n < 4; n++)
        upd_if.upd_digits[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lzb = ~lzb;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    upd_if.upd_valid = 1'b0;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
